// File: rtl/bus_arbiter_rr4_if.sv
// Bus-side signals shared by the four masters and the round-robin arbiter.
// The master modport drives requests; the slave modport is the arbiter's view.
interface bus_arbiter_rr4_if;
  logic [3:0] req;
  logic       bus_done;
  logic [3:0] gnt;
  logic [1:0] mux_sel;
  logic       bus_busy;
  logic       timeout_err;

  modport master (
    output req,
    output bus_done,
    input  gnt,
    input  mux_sel,
    input  bus_busy,
    input  timeout_err
  );

  modport slave (
    input  req,
    input  bus_done,
    output gnt,
    output mux_sel,
    output bus_busy,
    output timeout_err
  );
endinterface

// File: rtl/bus_arbiter_rr4.sv
// Four-master round-robin arbiter driving the shared bus mux select.
// A grant is held until bus_done, the owner drops its request, or the watchdog fires.
module bus_arbiter_rr4 #(
  parameter int TIMEOUT = 256,
  parameter int CNT_W   = 9
) (
  input  logic             clk,
  input  logic             rst_n,
  bus_arbiter_rr4_if.slave bus
);

  typedef enum logic {IDLE, GRANT} state_t;

  localparam logic             WD_EN    = (TIMEOUT != 0);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT != 0) ? CNT_W'(TIMEOUT - 1) : '0;

  state_t           state_q, state_d;
  logic [3:0]       gnt_q, gnt_d;
  logic [1:0]       sel_q, sel_d;
  logic [1:0]       last_q, last_d;
  logic             busy_q, busy_d;
  logic             terr_q, terr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       win;
  logic             owner_req;
  logic             wd_fire;

  // First requester after the previous owner; the previous owner is scanned last.
  function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] last);
    logic [1:0] idx;
    logic       found;
    rr_pick = last;
    found   = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      idx = last + 2'(k);
      if (!found && r[idx]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
    end
  endfunction

  assign win       = rr_pick(bus.req, last_q);
  assign owner_req = bus.req[sel_q];
  assign wd_fire   = WD_EN && (cnt_q == CNT_LAST);

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    sel_d   = sel_q;
    last_d  = last_q;
    busy_d  = busy_q;
    terr_d  = 1'b0;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (|bus.req) begin
          state_d = GRANT;
          gnt_d   = 4'b0001 << win;
          sel_d   = win;
          busy_d  = 1'b1;
          cnt_d   = '0;
        end
      end
      GRANT: begin
        if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
        // bus_done outranks an abandoned request, which outranks the watchdog.
        if (bus.bus_done || !owner_req || wd_fire) begin
          state_d = IDLE;
          gnt_d   = 4'b0000;
          busy_d  = 1'b0;
          last_d  = sel_q;
          terr_d  = !bus.bus_done && owner_req;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = 4'b0000;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gnt_q   <= 4'b0000;
      sel_q   <= 2'b00;
      last_q  <= 2'b11;
      busy_q  <= 1'b0;
      terr_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
      busy_q  <= busy_d;
      terr_q  <= terr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.gnt         = gnt_q;
  assign bus.mux_sel     = sel_q;
  assign bus.bus_busy    = busy_q;
  assign bus.timeout_err = terr_q;

  a_gnt_onehot0: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(gnt_q));
  a_busy_match:  assert property (@(posedge clk) disable iff (!rst_n) busy_q == (|gnt_q));

endmodule

// File: tb/tb_bus_arbiter_rr4.sv
// Directed bench for the round-robin arbiter with a cycle-level reference model.
module tb_bus_arbiter_rr4;

  localparam int TO = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  bus_arbiter_rr4_if bif();

  bus_arbiter_rr4 #(.TIMEOUT(TO), .CNT_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bif)
  );

  always #5 clk = ~clk;

  // Reference: owner index or -1 when idle, grant cycles held so far, last owner.
  int         m_owner = -1;
  int         m_last  = 3;
  int         m_held  = 0;
  logic [1:0] m_sel   = 2'b00;
  logic       m_terr  = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_owner = -1;
      m_last  = 3;
      m_held  = 0;
      m_sel   = 2'b00;
      m_terr  = 1'b0;
    end else if (m_owner < 0) begin
      m_terr = 1'b0;
      for (int k = 1; k <= 4; k++)
        if (m_owner < 0 && bif.req[(m_last + k) % 4]) m_owner = (m_last + k) % 4;
      if (m_owner >= 0) begin
        m_sel  = 2'(m_owner);
        m_held = 0;
      end
    end else begin
      m_terr = 1'b0;
      m_held = m_held + 1;
      if (bif.bus_done || !bif.req[m_owner] || (TO > 0 && m_held >= TO)) begin
        m_terr  = !bif.bus_done && bif.req[m_owner];
        m_last  = m_owner;
        m_owner = -1;
      end
    end
  end

  always @(negedge clk) begin
    logic [3:0] eg;
    logic       eb;
    eg = (m_owner < 0) ? 4'b0000 : 4'(1 << m_owner);
    eb = (m_owner >= 0);
    n_cmp++;
    if ({bif.gnt, bif.mux_sel, bif.bus_busy, bif.timeout_err} !== {eg, m_sel, eb, m_terr}) begin
      n_bad++;
      $display("FAIL model t=%0t: got gnt=%b sel=%b busy=%b terr=%b, want gnt=%b sel=%b busy=%b terr=%b",
               $time, bif.gnt, bif.mux_sel, bif.bus_busy, bif.timeout_err, eg, m_sel, eb, m_terr);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string nm, input logic [3:0] eg, input logic [1:0] es,
                     input logic eb, input logic et);
    n_cmp++;
    if ({bif.gnt, bif.mux_sel, bif.bus_busy, bif.timeout_err} !== {eg, es, eb, et}) begin
      n_bad++;
      $display("FAIL %s t=%0t: got gnt=%b sel=%b busy=%b terr=%b, want gnt=%b sel=%b busy=%b terr=%b",
               nm, $time, bif.gnt, bif.mux_sel, bif.bus_busy, bif.timeout_err, eg, es, eb, et);
    end
  endtask

  initial begin
    bif.req      = 4'b0000;
    bif.bus_done = 1'b0;
    repeat (2) cyc();
    chk("reset", 4'b0000, 2'b00, 1'b0, 1'b0);
    rst_n = 1'b1;

    // Full rotation with every master requesting.
    bif.req = 4'b1111;
    cyc(); chk("rr_g0", 4'b0001, 2'b00, 1'b1, 1'b0);
    for (int i = 1; i <= 4; i++) begin
      bif.bus_done = 1'b1; cyc(); bif.bus_done = 1'b0;
      chk("rr_dead", 4'b0000, 2'(i - 1), 1'b0, 1'b0);
      cyc(); chk("rr_gnt", 4'(1 << (i % 4)), 2'(i % 4), 1'b1, 1'b0);
    end
    bif.bus_done = 1'b1; cyc(); bif.bus_done = 1'b0; bif.req = 4'b0000;
    chk("rr_end", 4'b0000, 2'b00, 1'b0, 1'b0);
    cyc(); chk("rr_idle", 4'b0000, 2'b00, 1'b0, 1'b0);

    // Single master held five cycles; select sticks after release.
    bif.req = 4'b0100;
    cyc(); chk("hold_c1", 4'b0100, 2'b10, 1'b1, 1'b0);
    for (int k = 2; k <= 5; k++) begin
      cyc(); chk("hold_cn", 4'b0100, 2'b10, 1'b1, 1'b0);
    end
    bif.bus_done = 1'b1; bif.req = 4'b0000; cyc(); bif.bus_done = 1'b0;
    chk("hold_rel", 4'b0000, 2'b10, 1'b0, 1'b0);
    bif.bus_done = 1'b1; cyc(); bif.bus_done = 1'b0;
    chk("done_in_idle", 4'b0000, 2'b10, 1'b0, 1'b0);

    // Watchdog release after eight grant cycles, then re-grant.
    bif.req = 4'b0001;
    cyc(); chk("wd_c1", 4'b0001, 2'b00, 1'b1, 1'b0);
    for (int k = 2; k <= 8; k++) begin
      cyc(); chk("wd_cn", 4'b0001, 2'b00, 1'b1, 1'b0);
    end
    cyc(); chk("wd_release", 4'b0000, 2'b00, 1'b0, 1'b1);
    cyc(); chk("wd_regrant", 4'b0001, 2'b00, 1'b1, 1'b0);

    // bus_done in the final allowed cycle beats the watchdog.
    for (int k = 2; k <= 8; k++) begin
      cyc(); chk("race_cn", 4'b0001, 2'b00, 1'b1, 1'b0);
    end
    bif.bus_done = 1'b1; cyc(); bif.bus_done = 1'b0; bif.req = 4'b0000;
    chk("done_beats_wd", 4'b0000, 2'b00, 1'b0, 1'b0);
    cyc(); chk("race_idle", 4'b0000, 2'b00, 1'b0, 1'b0);

    // Owner abandons; other request changes ignored mid-grant.
    bif.req = 4'b0100;
    cyc(); chk("ab_g2", 4'b0100, 2'b10, 1'b1, 1'b0);
    bif.req = 4'b1111;
    cyc(); chk("nonowner_ignored", 4'b0100, 2'b10, 1'b1, 1'b0);
    bif.req = 4'b1001;
    cyc(); chk("abandon", 4'b0000, 2'b10, 1'b0, 1'b0);
    cyc(); chk("after_abandon", 4'b1000, 2'b11, 1'b1, 1'b0);

    // Asynchronous reset between clock edges.
    cyc(); chk("pre_rst", 4'b1000, 2'b11, 1'b1, 1'b0);
    #1 rst_n = 1'b0;
    #1 chk("async_rst", 4'b0000, 2'b00, 1'b0, 1'b0);
    bif.req = 4'b1010;
    cyc(); rst_n = 1'b1;
    chk("in_reset", 4'b0000, 2'b00, 1'b0, 1'b0);
    cyc(); chk("post_rst_m1", 4'b0010, 2'b01, 1'b1, 1'b0);
    bif.bus_done = 1'b1; cyc(); bif.bus_done = 1'b0; bif.req = 4'b0000;
    chk("final_rel", 4'b0000, 2'b01, 1'b0, 1'b0);
    cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
